// File: rtl/gate_checker.sv
// Truth-table sweeper: drives {a,b} 00..11, samples y_in and scores it against GATE_OP.
// Define GATE_CHECKER_CAPTURE_EN to keep the observed truth table on obs_tt.
module gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int GATE_OP       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [3:0] obs_tt
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] EXP_TT =
        (GATE_OP == 1) ? 4'b1110 :
        (GATE_OP == 2) ? 4'b0110 :
        (GATE_OP == 3) ? 4'b0111 : 4'b1000;

    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       mismatch;
    logic       accept;

    assign accept   = (state == IDLE) && start;
    assign mismatch = (state == SAMPLE) && (y_in != EXP_TT[idx]);
    assign {a, b}   = idx;
    assign busy     = (state == DRIVE) || (state == SETTLE) ||
                      (state == SAMPLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = DRIVE;
            DRIVE:  state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            SETTLE: if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE: state_nxt = (idx == 2'd3) ? DONE : DRIVE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx doubles as the {a,b} stimulus; it drops to 0 on leaving the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            if (accept) begin
                idx       <= '0;
                pass      <= 1'b0;
                err_count <= '0;
                fail_vec  <= '0;
            end
            if (state == DRIVE) cnt <= '0;
            if (state == SETTLE) cnt <= cnt + 4'd1;
            if (state == SAMPLE) begin
                if (mismatch) begin
                    err_count     <= err_count + 3'd1;
                    fail_vec[idx] <= 1'b1;
                end
                if (idx == 2'd3) begin
                    idx  <= '0;
                    pass <= (err_count == 3'd0) && !mismatch;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

`ifdef GATE_CHECKER_CAPTURE_EN
    logic [3:0] obs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_q <= '0;
        end else if (accept) begin
            obs_q <= '0;
        end else if (state == SAMPLE) begin
            obs_q[idx] <= y_in;
        end
    end

    assign obs_tt = obs_q;
`else
    assign obs_tt = '0;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: four instances, cycle-level model, directed sweeps.
// Honours GATE_CHECKER_CAPTURE_EN for obs_tt expectations.
module tb_gate_checker;

    localparam int SP [4] = '{2, 2, 0, 1};
    localparam int OP [4] = '{0, 3, 2, 5};

    typedef struct packed {
        logic [2:0] e;
        logic [3:0] f;
        logic [3:0] o;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start = '0;
    logic [3:0] a, b, y, busy, done, pass;
    logic [2:0] err [4];
    logic [3:0] fv [4];
    logic [3:0] obs [4];
    int         mode [4] = '{0, 3, 2, 0};

    int   checks = 0;
    int   errors = 0;
    int   t [4] = '{-1, -1, -1, -1};
    res_t h_res [4];
    logic h_pass [4];
    int   dc [4];
    int   dn [4];

    always #5 clk = ~clk;

    // mode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 constant 1
    function automatic logic gate(int m, logic x, logic z);
        case (m)
            1: return x | z;
            2: return x ^ z;
            3: return !(x & z);
            4: return 1'b1;
            default: return x & z;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign y[g] = gate(mode[g], a[g], b[g]);
        gate_checker #(
            .SETTLE_CYCLES(SP[g]),
            .GATE_OP      (OP[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .a        (a[g]),
            .b        (b[g]),
            .y_in     (y[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .pass     (pass[g]),
            .err_count(err[g]),
            .fail_vec (fv[g]),
            .obs_tt   (obs[g])
        );
    end

    // Scores of the first nv vectors, straight from the gate definitions
    function automatic res_t res(int k, int nv);
        res_t r;
        int   eop;
        logic yv, ev;
        r = '0;
        eop = (OP[k] >= 0 && OP[k] <= 3) ? OP[k] : 0;
        for (int v = 0; v < nv; v++) begin
            yv = gate(mode[k], v[1], v[0]);
            ev = gate(eop, v[1], v[0]);
            if (yv != ev) begin
                r.e++;
                r.f[v] = 1'b1;
            end
`ifdef GATE_CHECKER_CAPTURE_EN
            r.o[v] = yv;
`endif
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // t[k]: cycle number within the sweep (1 = DRIVE of vector 0), -1 idle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                t[k]      <= -1;
                h_res[k]  <= '0;
                h_pass[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (t[k] < 0) begin
                    if (start[k]) begin
                        t[k]      <= 1;
                        h_res[k]  <= '0;
                        h_pass[k] <= 1'b0;
                    end
                end else if (t[k] == 4 * (SP[k] + 2) + 1) begin
                    t[k]      <= -1;
                    h_res[k]  <= res(k, 4);
                    h_pass[k] <= (res(k, 4).e == 3'd0);
                end else begin
                    t[k] <= t[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int   per, vec;
            res_t r;
            logic eb, ed, ep;
            logic [1:0] ab;
            per = SP[k] + 2;
            ab = 2'd0;
            if (t[k] < 0) begin
                eb = 0; ed = 0;
                r = h_res[k];
                ep = h_pass[k];
            end else if (t[k] <= 4 * per) begin
                eb = 1; ed = 0; ep = 0;
                vec = (t[k] - 1) / per;
                ab = vec[1:0];
                r = res(k, vec);
            end else begin
                eb = 0; ed = 1;
                r = res(k, 4);
                ep = (r.e == 3'd0);
            end
            chk($sformatf("ab%0d", k), {a[k], b[k]}, ab);
            chk($sformatf("busy%0d", k), busy[k], eb);
            chk($sformatf("done%0d", k), done[k], ed);
            chk($sformatf("pass%0d", k), pass[k], ep);
            chk($sformatf("err%0d", k), err[k], r.e);
            chk($sformatf("fv%0d", k), fv[k], r.f);
            chk($sformatf("obs%0d", k), obs[k], r.o);
        end
    end

    // Start edge opens cycle 1; records done cycle and pulse counts
    task automatic sweep(logic [3:0] mask, int ncyc, int repulse);
        for (int k = 0; k < 4; k++) begin
            dc[k] = 0;
            dn[k] = 0;
        end
        @(posedge clk);
        #2 start = mask;
        @(posedge clk);
        #2 start = '0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (done[k]) begin
                    dn[k]++;
                    if (dc[k] == 0) dc[k] = n;
                end
            end
            if (n == repulse) #2 start = mask;
            else              #2 start = '0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 4'b0000);
        chk("rst_pass", pass, 4'b0000);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_auto_start", busy, 4'b0000);

        sweep(4'b1111, 30, 9);
        chk("and_done_cyc", dc[0], 17);
        chk("s0_done_cyc", dc[2], 9);
        chk("s1_done_cyc", dc[3], 13);
        chk("and_done_once", dn[0], 1);
        chk("s0_done_once", dn[2], 1);
        chk("and_pass", pass[0], 1'b1);
        chk("and_err", err[0], 3'd0);
        chk("and_fv", fv[0], 4'b0000);
        chk("nand_pass", pass[1], 1'b1);
        chk("badop_pass", pass[3], 1'b1);

        mode[0] = 1;
        mode[1] = 4;
        sweep(4'b0011, 22, 0);
        chk("or_err", err[0], 3'd2);
        chk("or_fv", fv[0], 4'b0110);
        chk("or_pass", pass[0], 1'b0);
`ifdef GATE_CHECKER_CAPTURE_EN
        chk("or_obs", obs[0], 4'b1110);
        chk("tie1_obs", obs[1], 4'b1111);
`else
        chk("or_obs", obs[0], 4'b0000);
`endif
        chk("tie1_err", err[1], 3'd1);
        chk("tie1_fv", fv[1], 4'b1000);
        chk("tie1_pass", pass[1], 1'b0);

        sweep(4'b0001, 10, 0);
        chk("pre_rst_busy", busy[0], 1'b1);
        chk("pre_rst_ab", {a[0], b[0]}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_ab", {a[0], b[0]}, 2'b00);
        chk("mid_rst_err", err[0], 3'd0);
        chk("mid_rst_fv", fv[0], 4'b0000);
        chk("mid_rst_obs", obs[0], 4'b0000);
        chk("mid_rst_pass", pass[0], 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        mode[0] = 0;
        repeat (2) @(negedge clk);
        sweep(4'b0001, 20, 0);
        chk("post_rst_cyc", dc[0], 17);
        chk("post_rst_pass", pass[0], 1'b1);
        chk("post_rst_err", err[0], 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning wait cycles between driving a vector and sampling y_in (legal 0..15).
REQ-002 Parameter GATE_OP, default 0, meaning expected gate: 0=AND, 1=OR, 2=XOR, 3=NAND.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request one full truth-table sweep.
REQ-006 Port a  output  1  registered stimulus bit A to the gate under check.
REQ-007 Port b  output  1  registered stimulus bit B to the gate under check.
REQ-008 Port y_in  input  1  gate output being checked.
REQ-009 Port busy  output  1  high while a sweep is in progress.
REQ-010 Port done  output  1  one-cycle pulse at sweep end.
REQ-011 Port pass  output  1  sweep result, 1 = no mismatches.
REQ-012 Port err_count  output  3  number of mismatching vectors, 0..4.
REQ-013 Port fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched.
REQ-014 Port obs_tt  output  4  observed truth table, bit i = sampled y_in for vector i.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE: start=1 at a clock edge SHALL move to DRIVE, set vector index to 0, and clear err_count, fail_vec, pass, obs_tt.
REQ-017 DRIVE (1 cycle): {a,b} SHALL equal the current index; next state SETTLE, or SAMPLE if SETTLE_CYCLES=0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles with {a,b} held, then go to SAMPLE.
REQ-019 SAMPLE (1 cycle): y_in SHALL be compared with expected bit; on mismatch, err_count increments and fail_vec[index] sets.
REQ-020 Expected table indexed by {a,b}: AND 4'b1000, OR 4'b1110, XOR 4'b0110, NAND 4'b0111.
REQ-021 From SAMPLE: index<3 -> increment index, go to DRIVE; index=3 -> go to DONE.
REQ-022 DONE (1 cycle): done=1, pass=(err_count==0) registered; next state IDLE.
REQ-023 Per-vector time SHALL be SETTLE_CYCLES+2 cycles; done SHALL be high in cycle 4*(SETTLE_CYCLES+2)+1 after the start edge.
REQ-024 busy SHALL be 1 in DRIVE, SETTLE, SAMPLE; 0 in IDLE and DONE.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 In IDLE, a=b=0; pass, err_count, fail_vec, obs_tt SHALL hold the last sweep result until the next accepted start.
REQ-027 Unsupported GATE_OP values SHALL be treated as AND.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, index 0, and a, b, busy, done, pass, err_count, fail_vec, obs_tt to 0, including mid-sweep.
REQ-029 After rst_n deasserts, the first sweep SHALL begin only on a new start.

Configuration
REQ-030 Macro GATE_CHECKER_CAPTURE_EN defined: obs_tt[index] SHALL be loaded with y_in in each SAMPLE cycle.
REQ-031 Macro GATE_CHECKER_CAPTURE_EN undefined: obs_tt SHALL be constant 0 and no capture register SHALL exist; all other behaviour unchanged.

Verification
REQ-032 GATE_OP=0, y_in=a&b, SETTLE_CYCLES=2, start pulse -> {a,b} steps 00,01,10,11; done in cycle 17; pass=1, err_count=0, fail_vec=4'b0000.
REQ-033 GATE_OP=0, y_in=a|b -> pass=0, err_count=2, fail_vec=4'b0110; with capture enabled obs_tt=4'b1110.
REQ-034 GATE_OP=3, y_in tied 1 -> err_count=1, fail_vec=4'b1000, pass=0.
REQ-035 start pulsed again while busy=1 -> ignored, done exactly once at the original cycle; SETTLE_CYCLES=0 -> done in cycle 9.
REQ-036 rst_n pulled low during vector 2 SETTLE -> all outputs 0 immediately, busy=0; new start gives a full correct sweep.
